// File: rtl/sync_fifo_pkg.sv
// Shared defaults and width helpers for the synchronous FIFO.
package sync_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32'sd8;
   localparam int DEF_DEPTH      = 32'sd8;
   localparam int DEF_AF_LEVEL   = 32'sd1;
   localparam int DEF_AE_LEVEL   = 32'sd1;

   // Pointer width; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      int w;
      if (depth > 32'sd2) begin
         w = $clog2(depth);
      end else begin
         w = 32'sd1;
      end
      return w;
   endfunction

   // Count width must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 32'sd1);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one write port, one registered read port.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AW         = ptr_width(DEF_DEPTH)
) (
   input  logic                  clk,
   input  logic                  aclr,
   input  logic                  sclr_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Storage array; deliberately not reset, empty gating hides stale words.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port; holds its value between accepted reads.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         rd_data_r <= '0;
      end else if (!sclr_n) begin
         rd_data_r <= '0;
      end else if (rd_en) begin
         rd_data_r <= mem_r[rd_addr];
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO control: pointers, word count, flags and overflow.
// Define SYNC_FIFO_OVERFLOW_EN to build the sticky overflow register.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_LEVEL   = DEF_AF_LEVEL,
   parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
   input  logic                          clk,
   input  logic                          aclr,
   input  logic                          sclr_n,
   input  logic [DATA_WIDTH-1:0]         din,
   input  logic                          wr_en,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          full,
   output logic                          almost_full,
   output logic                          empty,
   output logic                          almost_empty,
   output logic                          overflow,
   output logic [cnt_width(DEPTH)-1:0]   usedw
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          full_r;
   logic          empty_r;
   logic          af_r;
   logic          ae_r;
   logic          wr_acc_s;
   logic          rd_acc_s;

   // A write into a full FIFO is only legal when a read frees a slot that edge.
   assign wr_acc_s = sclr_n & wr_en & (~full_r | rd_en);
   assign rd_acc_s = sclr_n & rd_en & ~empty_r;

   // Next word count from the accepted read/write pair.
   always_comb begin
      cnt_nxt_s = cnt_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   cnt_nxt_s = cnt_r + CW'(1);
         2'b01:   cnt_nxt_s = cnt_r - CW'(1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Pointers, count and flags; flags are registered from the next count.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         af_r     <= 1'b0;
         ae_r     <= 1'b1;
      end else if (!sclr_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         af_r     <= 1'b0;
         ae_r     <= 1'b1;
      end else begin
         wr_ptr_r <= wr_acc_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
         rd_ptr_r <= rd_acc_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
         cnt_r    <= cnt_nxt_s;
         full_r   <= (cnt_nxt_s == CW'(DEPTH));
         empty_r  <= (cnt_nxt_s == CW'(0));
         af_r     <= (cnt_nxt_s >= CW'(DEPTH - AF_LEVEL));
         ae_r     <= (cnt_nxt_s <= CW'(AE_LEVEL));
      end
   end

`ifdef SYNC_FIFO_OVERFLOW_EN
   logic ovf_r;

   // Sticky overflow: a write attempt into a full FIFO with no read.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         ovf_r <= 1'b0;
      end else if (!sclr_n) begin
         ovf_r <= 1'b0;
      end else if (wr_en && full_r && !rd_en) begin
         ovf_r <= 1'b1;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign overflow = ovf_r;
`else
   assign overflow = 1'b0;
`endif

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (PW)
   ) u_mem (
      .clk     (clk),
      .aclr    (aclr),
      .sclr_n  (sclr_n),
      .wr_en   (wr_acc_s),
      .wr_addr (wr_ptr_r),
      .wr_data (din),
      .rd_en   (rd_acc_s),
      .rd_addr (rd_ptr_r),
      .rd_data (dout)
   );

   assign full         = full_r;
   assign empty        = empty_r;
   assign almost_full  = af_r;
   assign almost_empty = ae_r;
   assign usedw        = cnt_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH 8, DATA_WIDTH 8).
module tb_sync_fifo;

   logic       clk;
   logic       aclr;
   logic       sclr_n;
   logic [7:0] din;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] dout;
   logic       full;
   logic       almost_full;
   logic       empty;
   logic       almost_empty;
   logic       overflow;
   logic [3:0] usedw;

   int checks;
   int errors;

`ifdef SYNC_FIFO_OVERFLOW_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   sync_fifo dut (
      .clk          (clk),
      .aclr         (aclr),
      .sclr_n       (sclr_n),
      .din          (din),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .dout         (dout),
      .full         (full),
      .almost_full  (almost_full),
      .empty        (empty),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .usedw        (usedw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock: drive on the falling edge, outputs settle #1 after the rising edge.
   task automatic cycle(input logic w, input logic r, input logic [7:0] d);
      @(negedge clk);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic clear_sync();
      @(negedge clk);
      sclr_n = 1'b0;
      @(posedge clk);
      #1;
      sclr_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [5:0] st;
      aclr = 1'b1;
      #3;
      st = {empty, almost_empty, full, almost_full, overflow, |usedw};
      checks++;
      if (st !== 6'b110000) begin
         errors++;
         $display("FAIL aclr_flags: got %b expected %b", st, 6'b110000);
      end
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL aclr_dout: got %h expected 00", dout);
      end
      @(negedge clk);
      aclr = 1'b0;
      cycle(1'b1, 1'b0, 8'h11);
      cycle(1'b1, 1'b0, 8'h22);
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (usedw !== 4'd1 || dout !== 8'h11) begin
         errors++;
         $display("FAIL pre_clear: got usedw %0d dout %h expected 1 11", usedw, dout);
      end
      // Clear must win over a simultaneous write and read.
      @(negedge clk);
      sclr_n = 1'b0;
      wr_en  = 1'b1;
      rd_en  = 1'b1;
      din    = 8'h33;
      @(posedge clk);
      #1;
      sclr_n = 1'b1;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      st = {empty, almost_empty, full, almost_full, overflow, |usedw};
      checks++;
      if (st !== 6'b110000 || dout !== 8'h00) begin
         errors++;
         $display("FAIL sclr_state: got %b dout %h expected 110000 dout 00", st, dout);
      end
   endtask

   task automatic test_fill_drain();
      logic [7:0] vals [8];
      vals = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'hC3, 8'h5A};
      clear_sync();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, vals[i]);
         checks++;
         if (usedw !== 4'(i + 1)) begin
            errors++;
            $display("FAIL fill_usedw: got %0d expected %0d", usedw, i + 1);
         end
         if (i == 6) begin
            checks++;
            if (almost_full !== 1'b1 || full !== 1'b0) begin
               errors++;
               $display("FAIL fill7_flags: got af %b full %b expected 1 0", almost_full, full);
            end
         end else if (i == 5) begin
            checks++;
            if (almost_full !== 1'b0) begin
               errors++;
               $display("FAIL fill6_af: got %b expected 0", almost_full);
            end
         end
      end
      checks++;
      if (full !== 1'b1 || empty !== 1'b0) begin
         errors++;
         $display("FAIL fill8_full: got full %b empty %b expected 1 0", full, empty);
      end
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         checks++;
         if (dout !== vals[i]) begin
            errors++;
            $display("FAIL drain_dout[%0d]: got %h expected %h", i, dout, vals[i]);
         end
      end
      checks++;
      if (empty !== 1'b1 || usedw !== 4'd0) begin
         errors++;
         $display("FAIL drain_empty: got empty %b usedw %0d expected 1 0", empty, usedw);
      end
      // Read while empty is ignored and dout holds.
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (dout !== 8'h5A || usedw !== 4'd0) begin
         errors++;
         $display("FAIL empty_read: got dout %h usedw %0d expected 5a 0", dout, usedw);
      end
   endtask

   task automatic test_almost_empty();
      clear_sync();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(i));
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (usedw !== 4'd2 || almost_empty !== 1'b0) begin
         errors++;
         $display("FAIL ae_at2: got usedw %0d ae %b expected 2 0", usedw, almost_empty);
      end
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (usedw !== 4'd1 || almost_empty !== 1'b1 || empty !== 1'b0) begin
         errors++;
         $display("FAIL ae_at1: got usedw %0d ae %b empty %b expected 1 1 0", usedw, almost_empty, empty);
      end
   endtask

   task automatic test_simultaneous();
      clear_sync();
      cycle(1'b1, 1'b0, 8'h24);
      cycle(1'b1, 1'b0, 8'h56);
      cycle(1'b1, 1'b0, 8'h34);
      cycle(1'b1, 1'b0, 8'h98);
      cycle(1'b1, 1'b1, 8'h77);
      checks++;
      if (usedw !== 4'd4 || dout !== 8'h24) begin
         errors++;
         $display("FAIL simul_rw: got usedw %0d dout %h expected 4 24", usedw, dout);
      end
      // Empty with both requests: write only.
      clear_sync();
      cycle(1'b1, 1'b1, 8'hEE);
      checks++;
      if (usedw !== 4'd1 || dout !== 8'h00 || empty !== 1'b0) begin
         errors++;
         $display("FAIL empty_rw: got usedw %0d dout %h empty %b expected 1 00 0", usedw, dout, empty);
      end
      cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (dout !== 8'hEE) begin
         errors++;
         $display("FAIL empty_rw_data: got %h expected ee", dout);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      clear_sync();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h10 + 8'(i));
      cycle(1'b1, 1'b0, 8'h56);
      checks++;
      if (overflow !== OVF_EXP || usedw !== 4'd8) begin
         errors++;
         $display("FAIL overflow: got ovf %b usedw %0d expected %b 8", overflow, usedw, OVF_EXP);
      end
      // Full with both requests: both accepted, count stays at DEPTH.
      cycle(1'b1, 1'b1, 8'h99);
      checks++;
      if (usedw !== 4'd8 || dout !== 8'h10 || full !== 1'b1) begin
         errors++;
         $display("FAIL full_rw: got usedw %0d dout %h full %b expected 8 10 1", usedw, dout, full);
      end
      for (int i = 1; i < 9; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         exp = (i == 8) ? 8'h99 : 8'h10 + 8'(i);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL ovf_drain[%0d]: got %h expected %h", i, dout, exp);
         end
      end
      checks++;
      if (overflow !== OVF_EXP || empty !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf %b empty %b expected %b 1", overflow, empty, OVF_EXP);
      end
      clear_sync();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b expected 0", overflow);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      aclr = 1'b1;
      @(negedge clk);
      aclr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 1'b0, 8'(i));
         cycle(1'b0, 1'b1, 8'h00);
         checks++;
         if (dout !== 8'(i) || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap[%0d]: got dout %h empty %b expected %h 1", i, dout, empty, 8'(i));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sclr_n = 1'b1;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      din    = 8'h00;
      aclr   = 1'b0;
      test_reset();
      test_fill_drain();
      test_almost_empty();
      test_simultaneous();
      test_overflow();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning storage words; legal values are powers of two and at least 2.
REQ-003 The module SHALL have parameter AF_LEVEL, default 1, meaning the almost-full margin in words below DEPTH.
REQ-004 The module SHALL have parameter AE_LEVEL, default 1, meaning the almost-empty threshold in words.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-006 The module SHALL have port aclr, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The module SHALL have port sclr_n, input, 1 bit: synchronous clear, active-low.
REQ-008 The module SHALL have ports din (input, DATA_WIDTH, write data), wr_en (input, 1, write request) and rd_en (input, 1, read request).
REQ-009 The module SHALL have port dout, output, DATA_WIDTH: registered read data.
REQ-010 The module SHALL have ports full, almost_full, empty, almost_empty and overflow, each an output of 1 bit.
REQ-011 The module SHALL have port usedw, output, $clog2(DEPTH+1) bits: the current word count, 0..DEPTH.

Function
REQ-012 Write accepted = wr_en & (~full | rd_en); the word is stored at the write pointer, which then advances.
REQ-013 Read accepted = rd_en & ~empty; dout takes the head word on the same clock edge, so it is valid 1 cycle after rd_en is sampled.
REQ-014 dout SHALL hold its value when no read is accepted; a read while empty is ignored, with no state change.
REQ-015 usedw: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-016 When empty and both wr_en and rd_en are high, only the write is accepted and usedw becomes 1.
REQ-017 When full and both wr_en and rd_en are high, both are accepted and usedw stays DEPTH.
REQ-018 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-019 Flags SHALL be derived from usedw:
- full = (usedw == DEPTH)
- empty = (usedw == 0)
- almost_full = (usedw >= DEPTH-AF_LEVEL)
- almost_empty = (usedw <= AE_LEVEL)
REQ-020 overflow SHALL be registered: set on the edge where wr_en=1, full=1 and rd_en=0; it stays set (sticky) until reset or clear.
REQ-021 A rejected write SHALL NOT modify memory, pointers or usedw.

Reset
REQ-022 aclr=1 SHALL immediately clear the pointers, usedw and overflow, and set dout=0.
REQ-023 Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0, usedw=0, overflow=0.
REQ-024 sclr_n=0 at a clock edge SHALL produce the same state as aclr and has priority over wr_en and rd_en.
REQ-025 Memory contents need not be cleared; stale data SHALL never be visible because empty blocks reads.
REQ-026 Reset or clear mid-operation SHALL discard all stored words.

Configuration
REQ-027 With SYNC_FIFO_OVERFLOW_EN defined, overflow behaves per REQ-020.
REQ-028 Without SYNC_FIFO_OVERFLOW_EN, overflow SHALL be tied to 0 and no overflow register is built; the port remains present.

Structure
REQ-029 Package sync_fifo_pkg SHALL hold the default parameter constants and a helper function for the pointer and count widths.
REQ-030 Storage SHALL be one sub-module, sync_fifo_mem: a DEPTH x DATA_WIDTH register array with 1 write port and a registered read port.
REQ-031 The control logic (pointers, count, flags, overflow) SHALL reside in sync_fifo.

Verification
REQ-032 Reset: pulse aclr=1, then separately sclr_n=0 for 1 cycle -> empty=1, almost_empty=1, full=0, almost_full=0, usedw=0, overflow=0.
REQ-033 Fill and drain: write 8 random words, then read 8 -> dout matches in order; at 7 words almost_full=1 and full=0; at 8 words full=1, usedw=8; after draining, empty=1.
REQ-034 Almost-empty: fill to 8, then read down to usedw=1 -> almost_empty=1, empty=0.
REQ-035 Simultaneous access: write 24,56,34,98 (hex); assert wr_en and rd_en for 1 cycle -> usedw stays 4 and dout=0x24.
REQ-036 Overflow: fill to 8, then wr_en=1 with din=0x56 -> overflow=1, usedw=8, and 0x56 is not stored.
REQ-037 Wrap-around: reset, then 16 iterations of write i followed by read -> dout=i every time.
